shift_chain_error_counter: RTL
==============================

Name: shift_chain_error_counter

Overview:
Upstream stage of shifter_output. Drives a test pattern into four on-die shift chains (2x2 arrangement) and compares each chain's returned bit against a delayed copy of the pattern. Keeps one saturating 12-bit error count per chain. Periodically presents snapshot counts on SHIFT_ERROR_x_y with a SAVE_DATA strobe so the serializer can latch and ship them.

Parameters:
CHAIN_LEN, 64, flop depth of each shift chain under test
EXTRA_LAT, 0, additional board/pad latency in cycles on the return path
SAVE_PERIOD, 1024, cycles between SAVE_DATA rising edges (must be > SAVE_HIGH + 1)
SAVE_HIGH, 4, cycles SAVE_DATA stays high per period (>= 1)

Ports:
DATA_CLK  in  1  single clock; all logic on its rising edge
RST  in  1  asynchronous, active-high reset
ENABLE  in  1  level; high runs the test, low returns to IDLE
PATTERN_SEL  in  2  00 PRBS7, 01 all-0, 10 all-1, 11 alternating 0101...
CLR_COUNTS  in  1  synchronous clear of live counters
SHIFT_OUT  in  4  returned chain bits; [0]=0_0, [1]=0_1, [2]=1_0, [3]=1_1
SHIFT_IN  out  1  pattern bit broadcast to all four chains (registered)
SHIFT_ERROR_0_0 / _0_1 / _1_0 / _1_1  out  12 each  snapshot error counts
SAVE_DATA  out  1  snapshot-valid strobe for shifter_output
CHECKING  out  1  high while in CHECK state

Behaviour:
- Reset (RST high, async): state IDLE; SHIFT_IN=0; LFSR=7'h7F; alternating toggle=0; delay line all 0; live counters, snapshots and period counter 0; SAVE_DATA=0; CHECKING=0.
- Pattern generation: PRBS7 uses x^7+x^6+1, seed 7'h7F, and advances one step per cycle outside IDLE.
  - The first PRBS7 output bit after leaving IDLE is 1.
  - All-0 and all-1 modes drive constants.
  - Alternating mode starts at 0 and toggles each cycle.
  - PATTERN_SEL is sampled only on the IDLE->PRIME transition and ignored afterwards.
- Return path: SHIFT_OUT is registered once inside the block. Total compare delay is D = CHAIN_LEN + 1 + EXTRA_LAT. The expected bit is SHIFT_IN delayed by D cycles through an internal delay line.
- FSM:
  - IDLE: SHIFT_IN=0, pattern frozen. Goes to PRIME when ENABLE=1.
  - PRIME: pattern runs, no comparison. A fill counter runs 0..D-1; after D cycles, goes to CHECK.
  - CHECK: CHECKING=1. Each cycle, for each chain i, mismatch(i) = registered SHIFT_OUT[i] XOR expected.
  - ENABLE=0 in PRIME or CHECK returns to IDLE on the next edge. Live counters hold their values and the delay line is cleared.
- Live counters (12-bit each):
  - Increment by 1 on mismatch in CHECK; saturate at 4095 (no wrap).
  - CLR_COUNTS has priority over increment: count=0 on that edge.
  - Counters are cumulative until cleared or reset.
- Snapshot/strobe: the period counter runs free 0..SAVE_PERIOD-1 in every state and wraps to 0.
  - At count SAVE_PERIOD-1, the four snapshot registers load the live counters. If an increment happens on that same edge, the pre-increment value is loaded.
  - SAVE_DATA=1 while the period counter is in 0..SAVE_HIGH-1, so it rises one cycle after the snapshot load.
  - Snapshots change only at count SAVE_PERIOD-1, which keeps them stable for at least SAVE_PERIOD-1 cycles around the SAVE_DATA rising edge.
- Mid-operation reset: everything returns to reset values immediately. SAVE_DATA drops asynchronously.
- CLR_COUNTS does not affect snapshots, the FSM or the pattern.

Decomposition:
- Shared package shift_test_pkg: CNT_W=12, NUM_CHAINS=4, PRBS7 tap/seed constants, PATTERN_SEL encodings, and the FSM state enum (IDLE, PRIME, CHECK).
- One sub-module: pattern_gen (LFSR, constant and alternating modes; load/advance controls). The counters, delay line and FSM stay in the top.

Test Plan:
- Loopback: CHAIN_LEN=8, EXTRA_LAT=0, bench model of ideal 8-flop chains, PRBS7, ENABLE=1 for 2000 cycles -> CHECKING high from cycle 10 after ENABLE; all four counts 0 at every SAVE_DATA rise.
- Single-bit fault: invert SHIFT_OUT[2] for exactly 5 CHECK cycles -> next snapshot SHIFT_ERROR_1_0=5, the other three 0.
- Saturation: force SHIFT_OUT[0] stuck opposite the pattern for 5000 CHECK cycles in all-0 mode -> SHIFT_ERROR_0_0=4095 and holds; no wrap.
- Clear priority: assert CLR_COUNTS on the same edge as a mismatch -> live count 0, not 1; snapshot unchanged until the next period load.
- Strobe timing: SAVE_PERIOD=16, SAVE_HIGH=4 -> SAVE_DATA high for cycles 0-3 of each 16; snapshot changes only at cycle 15; no errors are counted during PRIME even with SHIFT_OUT toggling randomly.
- Reset mid-CHECK: assert RST asynchronously with counts at 37 -> all outputs 0 without waiting for a clock edge; after release, ENABLE=1 restarts PRIME with first PRBS7 bit 1.

Source files
------------

// File: rtl/shift_test_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_test_pkg
// Brief   : Shared constants, pattern encodings and FSM states for the
//           shift-chain error counter.
// Revision: 1.0 - initial release
// ============================================================================
package shift_test_pkg;

  localparam int CNT_W      = 12;
  localparam int NUM_CHAINS = 4;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the state).
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  localparam logic [1:0] PAT_PRBS7 = 2'b00;
  localparam logic [1:0] PAT_ZERO  = 2'b01;
  localparam logic [1:0] PAT_ONE   = 2'b10;
  localparam logic [1:0] PAT_ALT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2
  } state_t;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : pattern_gen
// Brief   : Test pattern source: PRBS7, constant 0/1 or alternating bits.
// Revision: 1.0 - initial release
// ============================================================================
module pattern_gen
  import shift_test_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_advance,
  input  logic [1:0] i_sel,
  output logic       o_bit
);

  logic [6:0] r_lfsr;
  logic       r_alt;
  logic [1:0] r_sel;
  logic [1:0] w_sel;

  // On the start edge the mode is taken straight from the input so the
  // first emitted bit already follows the newly selected pattern.
  assign w_sel = i_start ? i_sel : r_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= PRBS7_SEED;
      r_alt  <= 1'b0;
      r_sel  <= PAT_PRBS7;
    end else if (i_start) begin
      r_sel  <= i_sel;
      r_lfsr <= prbs7_step(PRBS7_SEED);
      r_alt  <= 1'b1;
    end else if (i_advance) begin
      r_lfsr <= prbs7_step(r_lfsr);
      r_alt  <= ~r_alt;
    end else begin
      r_lfsr <= PRBS7_SEED;
      r_alt  <= 1'b0;
    end
  end

  always_comb begin
    o_bit = 1'b0;
    case (w_sel)
      PAT_PRBS7: o_bit = r_lfsr[6];
      PAT_ZERO:  o_bit = 1'b0;
      PAT_ONE:   o_bit = 1'b1;
      PAT_ALT:   o_bit = r_alt;
      default:   o_bit = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_chain_error_counter.sv
`default_nettype none
// ============================================================================
// Module  : shift_chain_error_counter
// Brief   : Drives a pattern into four shift chains, counts per-chain return
//           errors and publishes periodic snapshots with a SAVE_DATA strobe.
// Revision: 1.0 - initial release
// ============================================================================
module shift_chain_error_counter
  import shift_test_pkg::*;
#(
  parameter int CHAIN_LEN   = 64,
  parameter int EXTRA_LAT   = 0,
  parameter int SAVE_PERIOD = 1024,
  parameter int SAVE_HIGH   = 4
) (
  input  logic             DATA_CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [1:0]       PATTERN_SEL,
  input  logic             CLR_COUNTS,
  input  logic [3:0]       SHIFT_OUT,
  output logic             SHIFT_IN,
  output logic [CNT_W-1:0] SHIFT_ERROR_0_0,
  output logic [CNT_W-1:0] SHIFT_ERROR_0_1,
  output logic [CNT_W-1:0] SHIFT_ERROR_1_0,
  output logic [CNT_W-1:0] SHIFT_ERROR_1_1,
  output logic             SAVE_DATA,
  output logic             CHECKING
);

  // Chain depth plus the input register on SHIFT_OUT plus board latency.
  localparam int C_DELAY   = CHAIN_LEN + 1 + EXTRA_LAT;
  localparam int C_FILL_W  = (C_DELAY > 1) ? $clog2(C_DELAY) : 1;
  localparam int C_PER_W   = $clog2(SAVE_PERIOD);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_start;
  logic                  w_run;
  logic [C_FILL_W-1:0]   r_fill;
  logic                  w_pat_bit;
  logic [NUM_CHAINS-1:0] r_shift_out;
  logic [C_DELAY-1:0]    r_dly;
  logic                  w_expected;
  logic [C_PER_W-1:0]    r_period;
  logic [C_PER_W-1:0]    w_period_next;
  logic                  w_period_last;
  logic [NUM_CHAINS-1:0][CNT_W-1:0] w_snap_bus;

  always_ff @(posedge DATA_CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      IDLE: begin
        if (ENABLE) begin
          w_next_state = PRIME;
          w_start      = 1'b1;
        end
      end
      PRIME: begin
        if (!ENABLE) begin
          w_next_state = IDLE;
        end else begin
          w_run = 1'b1;
          if (r_fill == C_FILL_W'(C_DELAY - 1)) w_next_state = CHECK;
        end
      end
      CHECK: begin
        if (!ENABLE) w_next_state = IDLE;
        else         w_run        = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign CHECKING = (r_state == CHECK);

  always_ff @(posedge DATA_CLK or posedge RST) begin
    if (RST)                                              r_fill <= '0;
    else if (r_state == PRIME && w_next_state == PRIME)   r_fill <= r_fill + 1'b1;
    else                                                  r_fill <= '0;
  end

  pattern_gen u_pattern_gen (
    .clk       (DATA_CLK),
    .rst       (RST),
    .i_start   (w_start),
    .i_advance (w_run),
    .i_sel     (PATTERN_SEL),
    .o_bit     (w_pat_bit)
  );

  always_ff @(posedge DATA_CLK or posedge RST) begin
    if (RST) begin
      SHIFT_IN    <= 1'b0;
      r_shift_out <= '0;
    end else begin
      SHIFT_IN    <= (w_start || w_run) ? w_pat_bit : 1'b0;
      r_shift_out <= SHIFT_OUT;
    end
  end

  // Expected-bit delay line; flushed whenever the test is stopped.
  always_ff @(posedge DATA_CLK or posedge RST) begin
    if (RST)          r_dly <= '0;
    else if (!ENABLE) r_dly <= '0;
    else              r_dly <= {r_dly[C_DELAY-2:0], SHIFT_IN};
  end

  assign w_expected = r_dly[C_DELAY-1];

  assign w_period_last = (r_period == C_PER_W'(SAVE_PERIOD - 1));
  assign w_period_next = w_period_last ? '0 : r_period + 1'b1;

  always_ff @(posedge DATA_CLK or posedge RST) begin
    if (RST) begin
      r_period  <= '0;
      SAVE_DATA <= 1'b0;
    end else begin
      r_period  <= w_period_next;
      SAVE_DATA <= (w_period_next < C_PER_W'(SAVE_HIGH));
    end
  end

  for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chain
    logic [CNT_W-1:0] r_live;
    logic [CNT_W-1:0] r_snap;
    logic             w_mismatch;

    assign w_mismatch = (r_state == CHECK) && (r_shift_out[gi] ^ w_expected);

    always_ff @(posedge DATA_CLK or posedge RST) begin
      if (RST)                                   r_live <= '0;
      else if (CLR_COUNTS)                       r_live <= '0;
      else if (w_mismatch && r_live != C_CNT_MAX) r_live <= r_live + 1'b1;
    end

    always_ff @(posedge DATA_CLK or posedge RST) begin
      if (RST)                r_snap <= '0;
      else if (w_period_last) r_snap <= r_live;
    end

    assign w_snap_bus[gi] = r_snap;
  end

  assign SHIFT_ERROR_0_0 = w_snap_bus[0];
  assign SHIFT_ERROR_0_1 = w_snap_bus[1];
  assign SHIFT_ERROR_1_0 = w_snap_bus[2];
  assign SHIFT_ERROR_1_1 = w_snap_bus[3];

endmodule
`default_nettype wire
